// File: rtl/johnson_decoder_pkg.sv
// Shared types and helpers for Johnson-code consumers: lock FSM states,
// code-for-index lookup and modular phase increment.
package johnson_decoder_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Phases 0..width fill ones from bit0 upward; later phases drain them from bit0.
  function automatic logic [31:0] jc_code(input int idx, input int width);
    if (idx <= width) jc_code = (32'd1 << idx) - 32'd1;
    else              jc_code = ((32'd1 << (2*width - idx)) - 32'd1) << (idx - width);
  endfunction

  function automatic int jc_inc(input int idx, input int n);
    jc_inc = (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational Johnson decoder: q -> phase index, legality flag and one-hot.
module johnson_code_lut
  import johnson_decoder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2*WIDTH)
)(
  input  logic [WIDTH-1:0]   q,
  output logic [IDX_W-1:0]   idx,
  output logic               legal,
  output logic [2*WIDTH-1:0] onehot
);

  localparam int N = 2*WIDTH;

  int          pc;
  int          ix;
  logic [31:0] code32;

  // Popcount picks the candidate phase; legality is confirmed by re-encoding it.
  always_comb begin
    pc     = int'($countones(q));
    ix     = q[WIDTH-1] ? (N - pc) : pc;
    idx    = IDX_W'(ix);
    code32 = jc_code(ix, WIDTH);
    legal  = (32'(q) == code32);
    onehot = '0;
    for (int i = 0; i < N; i++)
      onehot[i] = legal && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Registered Johnson-code decoder with sequence-lock monitor and error counter.
// Optional: JOHNSON_DECODER_AUTOCORRECT_EN predicts the next phase on a single illegal code while locked.
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = $clog2(2*WIDTH),
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
)(
  input  logic               clk,
  input  logic               clear,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               sample_en,
  output logic [IDX_W-1:0]   idx,
  output logic [2*WIDTH-1:0] onehot,
  output logic               code_valid,
  output logic               locked,
  output logic               seq_err,
  output logic [ERR_W-1:0]   err_count
);

  localparam int N     = 2*WIDTH;
  localparam int RUN_W = $clog2(LOCK_CNT+1);

  logic [IDX_W-1:0] lut_idx;
  logic             lut_legal;
  logic [N-1:0]     lut_onehot;

  johnson_code_lut #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lut (
    .q      (q_in),
    .idx    (lut_idx),
    .legal  (lut_legal),
    .onehot (lut_onehot)
  );

  lock_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_vld_q, prev_vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_inc;
  logic [IDX_W-1:0] pred_idx;
  logic             in_order;

  // prev_vld_q marks whether idx_q is a trustworthy reference for step/hold.
  assign pred_idx = IDX_W'(jc_inc(int'(idx_q), N));
  assign in_order = prev_vld_q && lut_legal && (lut_idx == idx_q || lut_idx == pred_idx);

`ifdef JOHNSON_DECODER_AUTOCORRECT_EN
  logic         bad_q, bad_d;
  logic [N-1:0] pred_oh;

  always_comb begin
    pred_oh = '0;
    for (int i = 0; i < N; i++)
      pred_oh[i] = (pred_idx == IDX_W'(i));
  end
`endif

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    prev_vld_d = prev_vld_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    valid_d    = valid_q;
    err_d      = err_q;
    seq_err_d  = 1'b0;
    err_inc    = 1'b0;
`ifdef JOHNSON_DECODER_AUTOCORRECT_EN
    bad_d      = bad_q;
`endif
    if (sample_en) begin
      valid_d    = lut_legal;
      onehot_d   = lut_onehot;
      prev_vld_d = lut_legal;
      if (lut_legal) idx_d = lut_idx;
      unique case (state_q)
        HUNT: begin
          if (!lut_legal) begin
            run_d   = '0;
            err_inc = 1'b1;
          end
          else if (!prev_vld_q) run_d = RUN_W'(1);
          else if (in_order)    run_d = run_q + RUN_W'(1);
          else                  run_d = '0;
          if (run_d == RUN_W'(LOCK_CNT)) begin
            state_d = LOCKED;
            run_d   = '0;
          end
        end
        LOCKED: begin
          if (!in_order) begin
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
            state_d   = HUNT;
            run_d     = '0;
          end
`ifdef JOHNSON_DECODER_AUTOCORRECT_EN
          bad_d = 1'b0;
          if (!lut_legal) begin
            idx_d    = pred_idx;
            onehot_d = pred_oh;
            // Ride through one glitch; a second consecutive one drops lock.
            if (!bad_q) begin
              state_d    = LOCKED;
              bad_d      = 1'b1;
              prev_vld_d = 1'b1;
            end
          end
`endif
        end
        default: state_d = HUNT;
      endcase
    end
    if (err_inc && err_q != '1) err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= HUNT;
      run_q      <= '0;
      prev_vld_q <= 1'b0;
      idx_q      <= '0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_vld_q <= prev_vld_d;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      seq_err_q  <= seq_err_d;
      err_q      <= err_d;
    end
  end

`ifdef JOHNSON_DECODER_AUTOCORRECT_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) bad_q <= 1'b0;
    else       bad_q <= bad_d;
  end
`endif

  assign idx        = idx_q;
  assign onehot     = onehot_q;
  assign code_valid = valid_q;
  assign locked     = (state_q == LOCKED);
  assign seq_err    = seq_err_q;
  assign err_count  = err_q;

endmodule
